lc3_mem_arbiter: RTL and testbench
==================================

Name: lc3_mem_arbiter

Overview:
- Sequences and shares the single-port LC3 main memory between two requesters: the CPU datapath (MAR/MDR path) and a program loader/debug port that fills memory before and during execution.
- Round-robin arbitration with one outstanding access at a time.
- Drives the memory's enable, write, address and data, and returns a per-requester ack plus read data.
- Sits between the datapath/loader and the memory array, under the full LC3 top level.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- RD_LAT, 1, cycles from mem_en (read) until mem_rdata is valid. Legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, level; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack is high.
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_W/DATA_W  loader equivalents of the CPU inputs.
- ldr_ack  out  1  loader completion pulse.
- ldr_rdata  out  DATA_W  loader read data, valid while ldr_ack is high.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high when state is not IDLE.
- owner  out  1  current/last grant: 0 = CPU, 1 = loader.

Behaviour:
- Reset (reset low, asynchronous), effective immediately:
  - state = IDLE; all outputs 0 (mem_*, acks, rdata register, busy).
  - owner = 1, so the CPU wins the first tie.
  - Any in-flight access is discarded with no ack.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req is high, select a requester and register its we/addr/wdata, then go to ISSUE.
  - Only one request: grant it.
  - Both requests: grant the requester that is not owner (round robin).
  - owner updates to the granted requester.
- ISSUE (exactly 1 cycle):
  - mem_en = 1; mem_we, mem_addr, mem_wdata come from the registered selection.
  - Next state: write -> ACK; read -> WAIT.
- WAIT (exactly RD_LAT cycles):
  - mem_en = 0; down-counter loaded with RD_LAT-1 at ISSUE.
  - On the last WAIT cycle, mem_rdata is captured into the shared rdata register. Then go to ACK.
- ACK (1 cycle):
  - The ack of the granted requester is 1; the other ack is 0. Then go to IDLE.
  - cpu_rdata and ldr_rdata are both driven from the rdata register.
  - rdata is unchanged by writes; it holds the last read value.
- Latency, with req first sampled in IDLE at cycle t:
  - mem_en is high at t+1.
  - Write: ack at t+2.
  - Read: ack at t+2+RD_LAT.
- Handshake rules:
  - Requester keeps req/we/addr/wdata stable from req rise until it samples ack.
  - req still high in the cycle after ack is treated as a new request (back-to-back access is legal). Round robin still applies if the other requester is waiting.
  - req dropped before ack is a protocol violation. The arbiter still completes the access and pulses ack.
- Non-granted request: waits with no side effects. Worst-case wait is one full access of the other requester.
- mem_en is never high for more than 1 consecutive cycle. There is never more than one outstanding access.
- cpu_ack and ldr_ack are never high together.
- No address translation or width arithmetic; address and data pass through registered.

Test Plan:
1. Reset then CPU read of 0x3000 (memory holds 0x1234), RD_LAT=1, req at t -> mem_en=1, mem_we=0, mem_addr=0x3000 at t+1 only; cpu_ack at t+3 with cpu_rdata=0x1234; ldr_ack stays 0.
2. CPU write 0x3001 <- 0xBEEF at t -> mem_en=mem_we=1, mem_wdata=0xBEEF at t+1; cpu_ack at t+2. A following CPU read of 0x3001 returns 0xBEEF.
3. Both reqs held high continuously from reset release, each access a write -> grants alternate CPU, LDR, CPU, LDR; owner toggles 0,1,0,1; acks never overlap.
4. Loader alone, three back-to-back writes to 0x3000-0x3002 (req held high) -> three ldr_acks at t+2, t+5, t+8. Memory contents match. busy drops only after the last ack.
5. CPU read in flight, reset asserted during WAIT -> mem_en, busy and cpu_ack go 0 immediately; no ack is issued. After release with req still high, the access restarts with mem_en one cycle after the IDLE sample.
6. RD_LAT=3, CPU read at t -> mem_en at t+1, WAIT spans t+2..t+4, cpu_ack at t+5 with data captured at the end of t+4.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_arbiter
// Purpose  : Round-robin sharing of the single-port LC3 main memory between
//            the CPU datapath and the program loader/debug port.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rdata_reg;
    logic              grant_ldr;

    // On a tie the requester that did not own the last grant wins.
    assign grant_ldr = ldr_req & (~cpu_req | ~owner);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rdata_reg <= '0;
            owner     <= 1'b1;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
        end else begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_req || ldr_req) begin
                        owner     <= grant_ldr;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_ldr ? ldr_we    : cpu_we;
                        mem_addr  <= grant_ldr ? ldr_addr  : cpu_addr;
                        mem_wdata <= grant_ldr ? ldr_wdata : cpu_wdata;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // mem_we still holds the selection made in IDLE here
                    if (mem_we) begin
                        cpu_ack <= ~owner;
                        ldr_ack <= owner;
                        state   <= S_ACK;
                    end else begin
                        cnt   <= CNT_W'(RD_LAT - 1);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        rdata_reg <= mem_rdata;
                        cpu_ack   <= ~owner;
                        ldr_ack   <= owner;
                        state     <= S_ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign cpu_rdata = rdata_reg;
    assign ldr_rdata = rdata_reg;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_mem_arbiter
// Purpose  : Directed self-checking bench; DUT A uses RD_LAT=1, DUT B RD_LAT=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // DUT A signals
    logic        a_cpu_req, a_cpu_we, a_ldr_req, a_ldr_we;
    logic [15:0] a_cpu_addr, a_cpu_wdata, a_ldr_addr, a_ldr_wdata;
    logic        a_cpu_ack, a_ldr_ack, a_mem_en, a_mem_we, a_busy, a_owner;
    logic [15:0] a_cpu_rdata, a_ldr_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

    // DUT B signals
    logic        b_cpu_req, b_cpu_we, b_ldr_req, b_ldr_we;
    logic [15:0] b_cpu_addr, b_cpu_wdata, b_ldr_addr, b_ldr_wdata;
    logic        b_cpu_ack, b_ldr_ack, b_mem_en, b_mem_we, b_busy, b_owner;
    logic [15:0] b_cpu_rdata, b_ldr_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) dut_a (
        .clk(clk), .reset(reset),
        .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr),
        .cpu_wdata(a_cpu_wdata), .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
        .ldr_req(a_ldr_req), .ldr_we(a_ldr_we), .ldr_addr(a_ldr_addr),
        .ldr_wdata(a_ldr_wdata), .ldr_ack(a_ldr_ack), .ldr_rdata(a_ldr_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .busy(a_busy), .owner(a_owner)
    );

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(3)) dut_b (
        .clk(clk), .reset(reset),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr),
        .cpu_wdata(b_cpu_wdata), .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .ldr_req(b_ldr_req), .ldr_we(b_ldr_we), .ldr_addr(b_ldr_addr),
        .ldr_wdata(b_ldr_wdata), .ldr_ack(b_ldr_ack), .ldr_rdata(b_ldr_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .busy(b_busy), .owner(b_owner)
    );

    // Memory models; read data outside the valid slot is poisoned with 0xDEAD
    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];
    logic [15:0] ra1 = 16'hDEAD;
    logic [15:0] rb1 = 16'hDEAD, rb2 = 16'hDEAD, rb3 = 16'hDEAD;

    always @(posedge clk) begin
        if (a_mem_en && a_mem_we) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
        ra1 <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr[7:0]] : 16'hDEAD;
        if (b_mem_en && b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
        rb1 <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr[7:0]] : 16'hDEAD;
        rb2 <= rb1;
        rb3 <= rb2;
    end
    assign a_mem_rdata = ra1;
    assign b_mem_rdata = rb3;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'h0000;
            mem_b[i] = 16'h0000;
        end
        mem_a[8'h00] = 16'h1234;
        mem_b[8'h00] = 16'hCAFE;
        reset = 1'b0;
        a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = 0; a_cpu_wdata = 0;
        a_ldr_req = 0; a_ldr_we = 0; a_ldr_addr = 0; a_ldr_wdata = 0;
        b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
        b_ldr_req = 0; b_ldr_we = 0; b_ldr_addr = 0; b_ldr_wdata = 0;

        // Reset state
        tick(2);
        check("rst_mem_en", a_mem_en, 0);
        check("rst_mem_we", a_mem_we, 0);
        check("rst_busy", a_busy, 0);
        check("rst_owner", a_owner, 1);
        check("rst_cpu_ack", a_cpu_ack, 0);
        check("rst_rdata", a_cpu_rdata, 16'h0000);
        reset = 1'b1;
        tick(1);

        // 1: CPU read 0x3000, RD_LAT=1
        a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 16'h3000;
        tick(1);
        check("t1_en", a_mem_en, 1);
        check("t1_we", a_mem_we, 0);
        check("t1_addr", a_mem_addr, 16'h3000);
        check("t1_owner", a_owner, 0);
        tick(1);
        check("t1_en_off", a_mem_en, 0);
        check("t1_ack_early", a_cpu_ack, 0);
        tick(1);
        check("t1_ack", a_cpu_ack, 1);
        check("t1_rdata", a_cpu_rdata, 16'h1234);
        check("t1_ldr_ack", a_ldr_ack, 0);
        a_cpu_req = 0;
        tick(1);
        check("t1_ack_off", a_cpu_ack, 0);
        check("t1_idle", a_busy, 0);

        // 2: CPU write 0x3001 <- 0xBEEF, then read it back
        a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 16'h3001; a_cpu_wdata = 16'hBEEF;
        tick(1);
        check("t2_en", a_mem_en, 1);
        check("t2_we", a_mem_we, 1);
        check("t2_addr", a_mem_addr, 16'h3001);
        check("t2_wdata", a_mem_wdata, 16'hBEEF);
        tick(1);
        check("t2_ack", a_cpu_ack, 1);
        check("t2_rdata_hold", a_cpu_rdata, 16'h1234);
        a_cpu_req = 0;
        tick(1);
        a_cpu_req = 1; a_cpu_we = 0;
        tick(3);
        check("t2_rd_ack", a_cpu_ack, 1);
        check("t2_rd_data", a_cpu_rdata, 16'hBEEF);
        a_cpu_req = 0;
        tick(1);

        // 3: both requesters hold req high from reset release, all writes
        reset = 1'b0;
        a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 16'h3010; a_cpu_wdata = 16'h1111;
        a_ldr_req = 1; a_ldr_we = 1; a_ldr_addr = 16'h3020; a_ldr_wdata = 16'h2222;
        tick(1);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(2);
            check($sformatf("t3_cpu_ack%0d", k), a_cpu_ack, (k % 2 == 0) ? 1 : 0);
            check($sformatf("t3_ldr_ack%0d", k), a_ldr_ack, (k % 2 == 1) ? 1 : 0);
            check($sformatf("t3_owner%0d", k), a_owner, (k % 2 == 1) ? 1 : 0);
            if (k == 3) begin
                a_cpu_req = 0;
                a_ldr_req = 0;
            end else if (k % 2 == 0) begin
                a_cpu_addr  = a_cpu_addr + 16'd1;
                a_cpu_wdata = a_cpu_wdata + 16'd1;
            end else begin
                a_ldr_addr  = a_ldr_addr + 16'd1;
                a_ldr_wdata = a_ldr_wdata + 16'd1;
            end
            tick(1);
        end
        tick(1);
        check("t3_idle", a_busy, 0);
        check("t3_mem10", mem_a[8'h10], 16'h1111);
        check("t3_mem11", mem_a[8'h11], 16'h1112);
        check("t3_mem20", mem_a[8'h20], 16'h2222);
        check("t3_mem21", mem_a[8'h21], 16'h2223);

        // 4: loader alone, three back-to-back writes
        a_ldr_req = 1; a_ldr_we = 1; a_ldr_addr = 16'h3000; a_ldr_wdata = 16'hA000;
        for (int k = 0; k < 3; k++) begin
            tick(2);
            check($sformatf("t4_ldr_ack%0d", k), a_ldr_ack, 1);
            check($sformatf("t4_cpu_ack%0d", k), a_cpu_ack, 0);
            check($sformatf("t4_busy%0d", k), a_busy, 1);
            if (k == 2) begin
                a_ldr_req = 0;
            end else begin
                a_ldr_addr  = a_ldr_addr + 16'd1;
                a_ldr_wdata = a_ldr_wdata + 16'd1;
            end
            tick(1);
        end
        check("t4_busy_end", a_busy, 0);
        tick(1);
        check("t4_still_idle", a_mem_en, 0);
        check("t4_mem0", mem_a[8'h00], 16'hA000);
        check("t4_mem1", mem_a[8'h01], 16'hA001);
        check("t4_mem2", mem_a[8'h02], 16'hA002);

        // 5: reset asserted while a CPU read sits in WAIT
        a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 16'h3002;
        tick(2);
        check("t5_wait_busy", a_busy, 1);
        #1 reset = 1'b0;
        #1;
        check("t5_rst_en", a_mem_en, 0);
        check("t5_rst_busy", a_busy, 0);
        check("t5_rst_ack", a_cpu_ack, 0);
        check("t5_rst_owner", a_owner, 1);
        tick(1);
        check("t5_no_ack", a_cpu_ack, 0);
        reset = 1'b1;
        tick(1);
        check("t5_restart_en", a_mem_en, 1);
        check("t5_restart_addr", a_mem_addr, 16'h3002);
        tick(2);
        check("t5_ack", a_cpu_ack, 1);
        check("t5_rdata", a_cpu_rdata, 16'hA002);
        a_cpu_req = 0;
        tick(1);

        // 6: RD_LAT=3 read on DUT B
        b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 16'h4000;
        tick(1);
        check("t6_en", b_mem_en, 1);
        check("t6_addr", b_mem_addr, 16'h4000);
        for (int k = 2; k <= 4; k++) begin
            tick(1);
            check($sformatf("t6_wait_en%0d", k), b_mem_en, 0);
            check($sformatf("t6_wait_busy%0d", k), b_busy, 1);
            check($sformatf("t6_wait_ack%0d", k), b_cpu_ack, 0);
        end
        tick(1);
        check("t6_ack", b_cpu_ack, 1);
        check("t6_rdata", b_cpu_rdata, 16'hCAFE);
        check("t6_ldr_ack", b_ldr_ack, 0);
        b_cpu_req = 0;
        tick(1);
        check("t6_ack_off", b_cpu_ack, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
